// File: rtl/sort_scheduler.sv
// Timestamped event queue feeding a one-at-a-time actuator gate scheduler.
// Optional statistics (drop_cnt, late_cnt, late) are built only when SORT_STATS_EN is defined.
module sort_scheduler #(
  parameter int DELAY = 100,
  parameter int WIDTH = 20,
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [1:0]               class_in,
  output logic                     gate_a,
  output logic                     gate_b,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     late,
  output logic [7:0]               drop_cnt,
  output logic [7:0]               late_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TS_W-1:0] DELAY_TS = TS_W'(DELAY);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [AW:0]     DEPTH_L  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIRE} state_t;

  logic [TS_W-1:0] r_ts;
  logic [TS_W+1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  state_t          r_state;
  logic [1:0]      r_cur_class;
  logic [TS_W-1:0] r_cur_target;
  logic [CW-1:0]   r_fire_cnt;
  logic            r_gate_a;
  logic            r_gate_b;

  logic            w_event;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic [TS_W+1:0] w_head;
  logic [TS_W-1:0] w_diff;
  logic            w_late;

  assign w_event = en & ((class_in == 2'b01) | (class_in == 2'b10));
  assign w_full  = (r_count == DEPTH_L);
  assign w_pop   = (r_state == S_IDLE) & (r_count != '0);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push  = w_event & (~w_full | w_pop);
  assign w_head  = r_mem[r_rd_ptr];
  // Modular distance to target; upper half of the range means the target has passed.
  assign w_diff  = r_cur_target - r_ts;
  assign w_late  = (r_state == S_WAIT) & w_diff[TS_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {class_in, r_ts + DELAY_TS};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cur_class  <= 2'b00;
      r_cur_target <= '0;
      r_fire_cnt   <= '0;
      r_gate_a     <= 1'b0;
      r_gate_b     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur_class  <= w_head[TS_W+1:TS_W];
            r_cur_target <= w_head[TS_W-1:0];
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if ((w_diff == '0) || w_late) begin
            r_state    <= S_FIRE;
            r_fire_cnt <= CNT_LOAD;
            r_gate_a   <= (r_cur_class == 2'b01);
            r_gate_b   <= (r_cur_class == 2'b10);
          end
        end
        S_FIRE: begin
          if (r_fire_cnt == '0) begin
            r_gate_a <= 1'b0;
            r_gate_b <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_fire_cnt <= r_fire_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gate_a     = r_gate_a;
  assign gate_b     = r_gate_b;
  assign fifo_level = r_count;
  assign busy       = (r_state != S_IDLE) | (r_count != '0);

`ifdef SORT_STATS_EN
  logic       w_drop;
  logic [7:0] r_drop_cnt;
  logic [7:0] r_late_cnt;

  assign w_drop = w_event & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
      r_late_cnt <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_late && (r_late_cnt != 8'hFF)) r_late_cnt <= r_late_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign late_cnt = r_late_cnt;
  assign late     = w_late;
`else
  assign drop_cnt = 8'd0;
  assign late_cnt = 8'd0;
  assign late     = 1'b0;
`endif

endmodule

// File: doc/sort_scheduler.md
Name: sort_scheduler

Overview:
- Sits downstream of the pulse classifier in the sorting system.
- Takes the 2-bit class strobe (01 = small pulse, 10 = large pulse), timestamps each event and queues it.
- Fires the matching actuator gate a fixed DELAY after detection, for WIDTH cycles.
- Serialises actuation, so only one gate is ever active at a time.

Parameters:
- DELAY, 100, cycles from class strobe to gate assertion; must satisfy 1 <= DELAY < 2^(TS_W-1).
- WIDTH, 20, gate active length in cycles; must be >= 1.
- DEPTH, 4, event FIFO depth; power of 2, >= 2.
- TS_W, 16, timestamp counter width in bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  accept new events when 1.
- class_in  in  2  classifier output; nonzero for one cycle per event.
- gate_a  out  1  actuator for class 01.
- gate_b  out  1  actuator for class 10.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- fifo_level  out  $clog2(DEPTH)+1  queued event count.
- late  out  1  one-cycle strobe; an actuation started after its target time.
- drop_cnt  out  8  events lost to a full FIFO; saturating.
- late_cnt  out  8  late actuations; saturating.

Behaviour:
- Reset:
  - Single clock domain; asynchronous active-low reset on rst_n.
  - On reset, all outputs, the timestamp counter, the FIFO pointers and the FSM go to 0/IDLE.
  - Reset mid-FIRE deasserts the gate immediately (asynchronously) and discards all queued events.
- Timestamp: ts is a free-running TS_W-bit counter that increments every cycle and wraps modulo 2^TS_W.
- Event capture: an event is class_in == 01 or 10 while en == 1.
  - 00 and 11 are ignored and are not counted.
  - Events while en == 0 are ignored and are not counted as drops.
- Push: entry {class, target = ts + DELAY mod 2^TS_W}, using ts in the cycle class_in is sampled. A push is accepted when:
  - the FIFO is not full, or
  - the FIFO is full but a pop occurs in the same cycle.
  - Otherwise the event is dropped and drop_cnt increments, saturating at 255.
- Simultaneous push and pop: both take effect and fifo_level is unchanged.
- FIFO: registered, fall-through head. fifo_level updates the cycle after the push/pop.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head into cur_class/cur_target and go to WAIT. Otherwise stay in IDLE.
  - WAIT: compute d = (cur_target - ts) mod 2^TS_W.
    - If d == 0: go to FIRE.
    - If d >= 2^(TS_W-1) (target already passed): go to FIRE, pulse late for 1 cycle, and increment late_cnt (saturating).
    - Otherwise stay in WAIT.
  - FIRE: the gate for cur_class is high for exactly WIDTH cycles, starting the cycle after the WAIT->FIRE transition.
    - The countdown is loaded with WIDTH-1 on entry.
    - When the count reaches 0, the gate drops and the FSM goes to IDLE.
- Latency:
  - The class strobe at cycle t, with an empty FIFO and the FSM in IDLE, gives a gate rising at t+DELAY+1.
  - Between back-to-back actuations there is a minimum of 2 gate-low cycles (FIRE->IDLE->WAIT).
  - Two events closer together than WIDTH+2 cycles cause the second one to fire late.
- Gates: gate_a and gate_b are never high together; both are registered outputs.
- Wrap-around: the target computation and the compare use modular arithmetic only, so a target that crosses the ts wrap fires at the correct time.
- busy = (state != IDLE) | (fifo_level != 0).

Optional Feature:
- SORT_STATS_EN defined: drop_cnt, late_cnt and the late strobe are implemented as described.
- SORT_STATS_EN undefined:
  - drop_cnt, late_cnt and late are tied to 0 and their counter registers are omitted.
  - Scheduling, dropping and late firing are unchanged.

Test Plan:
- Single event: DELAY=100, WIDTH=20. Class 01 strobe at cycle 10 -> gate_a high cycles 111..130, gate_b stays 0, late never asserts, busy falls after cycle 130.
- Class mapping and invalid codes: strobe 10 at cycle 0, then 11 and 00 -> only one gate_b pulse of 20 cycles, fifo_level peaks at 1.
- Back-to-back: class 01 at cycle 0 and class 10 at cycle 5 -> gate_a 101..120; gate_b rises at 123 with a late strobe at 122; late_cnt = 1.
- Overflow: DEPTH=4, 6 strobes on consecutive cycles starting while IDLE -> first pops immediately, 4 queued, 1 dropped, drop_cnt = 1. Push into a full FIFO coinciding with a pop is accepted.
- Wrap: TS_W=8, DELAY=100, strobe at ts=200 -> target 44; gate rises at ts=45 after the wrap, with no late strobe.
- Reset and enable:
  - Assert rst_n low mid-FIRE -> gates drop immediately, fifo_level 0, counters 0.
  - en=0 with strobes -> no queueing and drop_cnt stays 0.
  - Rebuild without SORT_STATS_EN -> counters read 0 for the same stimulus.
